// File: rtl/fifo_sync_flex.sv
//============================================================================
// Module   : fifo_sync_flex
// Brief    : Single-clock FIFO, any depth >= 2, exact level, AF/AE flags, flush.
//            Define FIFO_ERR_EN to add sticky overflow/underflow outputs.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module fifo_sync_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_dv,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  input  logic                         rd_en,
  output logic                         rd_dv,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
`ifdef FIFO_ERR_EN
  output logic                         overflow,
  output logic                         underflow,
`endif
  output logic                         almost_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(DEPTH - 1);
  localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_AF      = c_LVL_W'(AF_THRESH);
  localparam logic [c_LVL_W-1:0] c_AE      = c_LVL_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0]    r_level;
  logic                  r_rd_dv;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_level == c_DEPTH_L);
  assign w_empty  = (r_level == '0);
  // Acceptance uses pre-edge flags only, so a full FIFO drops a write even
  // when a read drains an entry on the same edge.
  assign w_wr_acc = wr_dv && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_dv   <= 1'b0;
      r_rd_data <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rd_dv  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_dv <= w_rd_acc;
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

`ifdef FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_dv && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign level        = r_level;
  assign almost_full  = (r_level >= c_AF);
  assign almost_empty = (r_level <= c_AE);
  assign rd_dv        = r_rd_dv;
  assign rd_data      = r_rd_data;

endmodule

`default_nettype wire
